// File: rtl/kbd_event_decoder_if.sv
// rtl/kbd_event_decoder_if.sv - scan-byte input and event-FIFO read bundle for kbd_event_decoder
interface kbd_event_decoder_if #(
    parameter int FIFO_AW = 3
);
    logic              scan_valid;
    logic [7:0]        scan_code;
    logic              rd_en;
    logic [14:0]       rd_data;
    logic              empty;
    logic              full;
    logic [FIFO_AW:0]  count;
    logic              overflow;
    logic              ov_clr;
    logic              caps_led;

    modport master (
        output scan_valid, scan_code, rd_en, ov_clr,
        input  rd_data, empty, full, count, overflow, caps_led
    );

    modport slave (
        input  scan_valid, scan_code, rd_en, ov_clr,
        output rd_data, empty, full, count, overflow, caps_led
    );
endinterface

// File: rtl/kbd_event_decoder.sv
// rtl/kbd_event_decoder.sv - PS/2 set-2 byte decoder with modifier tracking and show-ahead event FIFO
module kbd_event_decoder #(
    parameter int FIFO_AW          = 3,
    parameter int REPORT_BREAKS    = 0,
    parameter int TYPEMATIC_FILTER = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    kbd_event_decoder_if.slave   bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK,
        S_PAUSE
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          skip_q, skip_d;
    logic [5:0]          mod_q, mod_d;
    logic                caps_q, caps_d;
    logic                caps_held_q, caps_held_d;
    logic [9:0]          held_q, held_d;
    logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]    count_q, count_d;
    logic                overflow_q, overflow_d;
    logic [14:0]         mem_q [DEPTH];

    logic                ev_valid, ev_ext, ev_brk;
    logic [7:0]          ev_code;
    logic [5:0]          mod_sel;
    logic                is_caps, held_match, push;
    logic                shift, ctrl, alt;
    logic [14:0]         entry;
    logic                empty, full, do_pop, do_wr, drop;

    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        ev_valid = 1'b0;
        ev_ext   = 1'b0;
        ev_brk   = 1'b0;
        ev_code  = bus.scan_code;
        if (bus.scan_valid) begin
            case (state_q)
                S_IDLE: begin
                    case (bus.scan_code)
                        8'hE0: state_d = S_EXT;
                        8'hF0: state_d = S_BRK;
                        8'hE1: begin
                            state_d = S_PAUSE;
                            skip_d  = 3'd7;
                        end
                        8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
                        default: ev_valid = 1'b1;
                    endcase
                end
                S_EXT: begin
                    if (bus.scan_code == 8'hF0) begin
                        state_d = S_EXT_BRK;
                    end else begin
                        ev_valid = 1'b1;
                        ev_ext   = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                S_BRK: begin
                    ev_valid = 1'b1;
                    ev_brk   = 1'b1;
                    state_d  = S_IDLE;
                end
                S_EXT_BRK: begin
                    ev_valid = 1'b1;
                    ev_ext   = 1'b1;
                    ev_brk   = 1'b1;
                    state_d  = S_IDLE;
                end
                S_PAUSE: begin
                    // the E1 pause sequence carries seven trailing bytes with no key meaning
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        mod_sel = 6'b000000;
        case ({ev_ext, ev_code})
            {1'b0, 8'h12}: mod_sel = 6'b000001;
            {1'b0, 8'h59}: mod_sel = 6'b000010;
            {1'b0, 8'h14}: mod_sel = 6'b000100;
            {1'b1, 8'h14}: mod_sel = 6'b001000;
            {1'b0, 8'h11}: mod_sel = 6'b010000;
            {1'b1, 8'h11}: mod_sel = 6'b100000;
            default:       mod_sel = 6'b000000;
        endcase
    end

    assign is_caps    = !ev_ext && (ev_code == 8'h58);
    assign held_match = held_q[9] && (held_q[8:0] == {ev_ext, ev_code});
    assign shift      = mod_q[0] | mod_q[1];
    assign ctrl       = mod_q[2] | mod_q[3];
    assign alt        = mod_q[4] | mod_q[5];
    // flags come from the pre-event modifier state, so a break reports what was held before it
    assign entry      = {shift ^ caps_q, caps_q, alt, ctrl, shift, ev_brk, ev_ext, ev_code};

    always_comb begin
        mod_d       = mod_q;
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
        held_d      = held_q;
        push        = 1'b0;
        if (ev_valid) begin
            if (mod_sel != 6'b000000) begin
                mod_d = ev_brk ? (mod_q & ~mod_sel) : (mod_q | mod_sel);
            end else if (is_caps) begin
                if (ev_brk) begin
                    caps_held_d = 1'b0;
                end else if (!caps_held_q) begin
                    caps_d      = ~caps_q;
                    caps_held_d = 1'b1;
                end
            end else if (ev_brk) begin
                if (held_match) held_d[9] = 1'b0;
                push = (REPORT_BREAKS != 0);
            end else if (!((TYPEMATIC_FILTER != 0) && held_match)) begin
                push   = 1'b1;
                held_d = {1'b1, ev_ext, ev_code};
            end
        end
    end

    assign empty  = (count_q == '0);
    assign full   = count_q[FIFO_AW];
    assign do_pop = bus.rd_en && !empty;
    // a pop in the same cycle frees the slot a full-FIFO push needs
    assign do_wr  = push && (!full || do_pop);
    assign drop   = push && full && !do_pop;

    always_comb begin
        wr_ptr_d   = do_wr  ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d   = do_pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        count_d    = count_q;
        if (do_wr && !do_pop)      count_d = count_q + CNT_ONE;
        else if (!do_wr && do_pop) count_d = count_q - CNT_ONE;
        overflow_d = overflow_q;
        if (drop)            overflow_d = 1'b1;
        else if (bus.ov_clr) overflow_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            skip_q      <= 3'd0;
            mod_q       <= 6'b000000;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
            held_q      <= 10'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            mod_q       <= mod_d;
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
            held_q      <= held_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && do_wr) mem_q[wr_ptr_q] <= entry;
    end

    assign bus.rd_data  = mem_q[rd_ptr_q];
    assign bus.empty    = empty;
    assign bus.full     = full;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.caps_led = caps_q;
endmodule
